// File: rtl/fir_pkg.sv
// Shared constants and helpers for the configurable FIR pipeline.
// Latency: none (package only).
// Backpressure: not applicable.
package fir_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_COEF_W = 16;
    localparam int DEF_NTAPS  = 123;
    localparam int DEF_FRAC   = 14;

    // Working width for the round/saturate helper; accumulators up to 64 bits.
    localparam int RS_W = 64;

    typedef struct packed {
        logic                   sat;
        logic signed [RS_W-1:0] val;
    } rs_t;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >>> 1) r++;
        return r;
    endfunction

    // Round half-up at bit frac, arithmetic shift right by frac, then clip
    // to a signed out_w-bit range. sat flags that clipping happened.
    function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                      input int frac, input int out_w);
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] hi;
        logic signed [RS_W-1:0] lo;
        rs_t res;
        one = RS_W'(1);
        r   = acc;
        if (frac > 0) r = (acc + (one <<< (frac - 1))) >>> frac;
        hi = (one <<< (out_w - 1)) - one;
        lo = -(one <<< (out_w - 1));
        res.sat = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.val = hi;
            res.sat = 1'b1;
        end else if (r < lo) begin
            res.val = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_pipe_cfg_if.sv
// Sample stream, coefficient programming and filtered output bundle.
// Latency: none (wires only).
// Backpressure: none; the stream is valid-only.
// master drives samples and coefficient writes/swaps, slave (the filter)
// drives out_valid/out_data/out_sat.
interface fir_pipe_cfg_if import fir_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     coef_we;
    logic [7:0]               coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_swap;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, coef_we, coef_addr, coef_wdata, coef_swap,
        input  out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, coef_we, coef_addr, coef_wdata, coef_swap,
        output out_valid, out_data, out_sat
    );
endinterface

// File: rtl/fir_adder_tree.sv
// Registered binary adder tree summing N signed inputs at full width.
// Latency: clog2(N) cycles, one register per tree level.
// Backpressure: none; advances every cycle.
// Ports: clk, rst (sync, active-high), din[N] (IN_W each), dout (IN_W+clog2(N)).
module fir_adder_tree import fir_pkg::*; #(
    parameter int N    = 8,
    parameter int IN_W = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [IN_W-1:0]             din [N],
    output logic signed [IN_W+clog2(N)-1:0]    dout
);
    localparam int T     = clog2(N);
    localparam int OUT_W = IN_W + T;
    localparam int P     = 1 << T;

    // Heap layout: heap[0..P-2] are the registered internal nodes, heap[P-1..2P-2]
    // are the leaves (inputs sign-extended, missing inputs padded with zero).
    // Every leaf sits at the same depth, so all paths see exactly T registers.
    logic signed [OUT_W-1:0] node [P-1];
    logic signed [OUT_W-1:0] heap [2*P-1];

    always_comb begin
        for (int i = 0; i < 2*P-1; i++) heap[i] = '0;
        for (int i = 0; i < P-1; i++)   heap[i] = node[i];
        for (int i = 0; i < N; i++)     heap[P-1+i] = OUT_W'(din[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < P-1; k++) node[k] <= '0;
        end else begin
            for (int k = 0; k < P-1; k++) node[k] <= heap[2*k+1] + heap[2*k+2];
        end
    end

    assign dout = node[0];

endmodule

// File: rtl/fir_pipe_cfg.sv
// Pipelined FIR with double-buffered (shadow/active) coefficient banks.
// Latency: clog2(NTAPS)+2 cycles from accepting edge to out_valid.
// Backpressure: none; every accepted sample produces one output.
// Ports: clk, rst (sync, active-high), io (slave side of fir_pipe_cfg_if).
module fir_pipe_cfg import fir_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int NTAPS  = DEF_NTAPS,
    parameter int FRAC   = DEF_FRAC
) (
    input  logic          clk,
    input  logic          rst,
    fir_pipe_cfg_if.slave io
);
    localparam int T      = clog2(NTAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + T;

    logic signed [DATA_W-1:0] taps   [NTAPS];
    logic signed [COEF_W-1:0] shadow [NTAPS];
    logic signed [COEF_W-1:0] active [NTAPS];
    logic signed [PROD_W-1:0] prod   [NTAPS];
    logic signed [ACC_W-1:0]  acc;
    logic                     v_line;
    logic                     v_prod;
    logic [T-1:0]             v_tree;
    rs_t                      rs;
    logic                     unused_hi;

    // Delay line moves only on accepted samples; v_line tags the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) taps[i] <= '0;
            v_line <= 1'b0;
        end else begin
            v_line <= io.in_valid;
            if (io.in_valid) begin
                taps[0] <= io.in_data;
                for (int i = 1; i < NTAPS; i++) taps[i] <= taps[i-1];
            end
        end
    end

    // Swap copies the shadow contents as they were before this edge, so a
    // simultaneous write lands only in shadow. Out-of-range addresses match
    // no entry and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (io.coef_swap) begin
                for (int i = 0; i < NTAPS; i++) active[i] <= shadow[i];
            end
            if (io.coef_we) begin
                for (int i = 0; i < NTAPS; i++) begin
                    if (io.coef_addr == 8'(i)) shadow[i] <= io.coef_wdata;
                end
            end
        end
    end

    // Full-width products; a sample's products all use the bank that was
    // active on the edge they are captured, so no tap mixes old and new.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NTAPS; i++) prod[i] <= '0;
            v_prod <= 1'b0;
        end else begin
            for (int i = 0; i < NTAPS; i++) prod[i] <= PROD_W'(taps[i]) * PROD_W'(active[i]);
            v_prod <= v_line;
        end
    end

    fir_adder_tree #(
        .N    (NTAPS),
        .IN_W (PROD_W)
    ) u_tree (
        .clk  (clk),
        .rst  (rst),
        .din  (prod),
        .dout (acc)
    );

    // Valid flag walks alongside the tree levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_tree <= '0;
        end else begin
            v_tree[0] <= v_prod;
            for (int i = 1; i < T; i++) v_tree[i] <= v_tree[i-1];
        end
    end

    always_comb rs = round_sat(RS_W'(acc), FRAC, DATA_W);

    // Upper bits are sign copies after clipping.
    assign unused_hi = ^rs.val[RS_W-1:DATA_W];

    // Data and sat only update on valid, so they hold between outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            io.out_valid <= 1'b0;
            io.out_data  <= '0;
            io.out_sat   <= 1'b0;
        end else begin
            io.out_valid <= v_tree[T-1];
            if (v_tree[T-1]) begin
                io.out_data <= rs.val[DATA_W-1:0];
                io.out_sat  <= rs.sat;
            end
        end
    end

endmodule

// File: tb/tb_fir_pipe_cfg.sv
// Directed testbench for fir_pipe_cfg with an 8-tap, Q14 configuration.
// Latency: expects outputs 5 cycles after each accepting edge.
// Backpressure: none exercised; the DUT has none.
module tb_fir_pipe_cfg;
    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int NTAPS  = 8;
    localparam int FRAC   = 14;
    localparam int LAT    = 5;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cset [NTAPS];

    always #5 clk = ~clk;

    fir_pipe_cfg_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) bus ();

    fir_pipe_cfg #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .NTAPS  (NTAPS),
        .FRAC   (FRAC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.coef_swap  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic load_shadow();
        for (int i = 0; i < NTAPS; i++) begin
            bus.coef_we    = 1'b1;
            bus.coef_addr  = 8'(i);
            bus.coef_wdata = COEF_W'(cset[i]);
            step();
        end
        bus.coef_we = 1'b0;
    endtask

    task automatic swap_bank();
        bus.coef_swap = 1'b1;
        step();
        bus.coef_swap = 1'b0;
    endtask

    task automatic drive(input logic v, input int d);
        bus.in_valid = v;
        bus.in_data  = DATA_W'(d);
        step();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_data    = DATA_W'(32767);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = 8'd0;
        bus.coef_wdata = COEF_W'(5);
        bus.coef_swap  = 1'b1;
        step();
        step();
        tests++;
        if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        tests++;
        if (bus.out_data !== 16'sd0) begin fails++; $display("FAIL reset_data: got %0d want 0", bus.out_data); end
        tests++;
        if (bus.out_sat !== 1'b0) begin fails++; $display("FAIL reset_sat: got %b want 0", bus.out_sat); end
        idle_inputs();
        rst = 1'b0;
        for (int c = 0; c < LAT + 3; c++) begin
            step();
            tests++;
            if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_idle c=%0d: out_valid %b want 0", c, bus.out_valid); end
        end
    endtask

    task automatic test_impulse();
        int   k;
        logic ev;
        do_reset();
        cset = '{1, 2, 3, 4, 5, 6, 7, 8};
        load_shadow();
        // Out-of-range write must not alias onto tap 0.
        bus.coef_we = 1'b1; bus.coef_addr = 8'd8; bus.coef_wdata = COEF_W'(999);
        step();
        bus.coef_we = 1'b0;
        swap_bank();
        for (int c = 0; c < 8 + LAT + 3; c++) begin
            drive(c < 8, (c == 0) ? 16384 : 0);
            k  = c - LAT;
            ev = (k >= 0) && (k < 8);
            tests++;
            if (bus.out_valid !== ev) begin fails++; $display("FAIL impulse_valid c=%0d: got %b want %b", c, bus.out_valid, ev); end
            if (ev) begin
                tests++;
                if (bus.out_data !== DATA_W'(k + 1)) begin fails++; $display("FAIL impulse_data k=%0d: got %0d want %0d", k, bus.out_data, k + 1); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_bubbles();
        int       s [4];
        int       y [4];
        logic [6:0] pat;
        int       si;
        int       n;
        int       k;
        int       exp_d;
        logic     ev;
        s = '{16384, 8192, -16384, 4096};
        y = '{1, 3, 3, 4};
        for (int p = 0; p < 2; p++) begin
            do_reset();
            cset = '{1, 2, 3, 4, 5, 6, 7, 8};
            load_shadow();
            swap_bank();
            pat = (p == 1) ? 7'b1011001 : 7'b0001111;
            si = 0;
            n  = 0;
            for (int c = 0; c < 7 + LAT + 2; c++) begin
                if (c < 7 && pat[c]) begin
                    drive(1'b1, s[si]);
                    si++;
                end else begin
                    drive(1'b0, 4660);
                end
                k  = c - LAT;
                ev = 1'b0;
                if (k >= 0 && k < 7) ev = pat[k];
                tests++;
                if (bus.out_valid !== ev) begin fails++; $display("FAIL bubble_valid p=%0d c=%0d: got %b want %b", p, c, bus.out_valid, ev); end
                if (ev) begin
                    exp_d = y[n];
                    n++;
                end else begin
                    exp_d = (n > 0) ? y[n-1] : 0;
                end
                tests++;
                if (bus.out_data !== DATA_W'(exp_d)) begin fails++; $display("FAIL bubble_data p=%0d c=%0d: got %0d want %0d", p, c, bus.out_data, exp_d); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_rounding();
        int   s [4];
        int   y [4];
        int   k;
        logic ev;
        s = '{8192, 8191, -8192, -8193};
        y = '{1, 0, 0, -1};
        do_reset();
        cset = '{1, 0, 0, 0, 0, 0, 0, 0};
        load_shadow();
        swap_bank();
        for (int c = 0; c < 4 + LAT + 1; c++) begin
            drive(c < 4, (c < 4) ? s[c] : 0);
            k  = c - LAT;
            ev = (k >= 0) && (k < 4);
            tests++;
            if (bus.out_valid !== ev) begin fails++; $display("FAIL round_valid c=%0d: got %b want %b", c, bus.out_valid, ev); end
            if (ev) begin
                tests++;
                if (bus.out_data !== DATA_W'(y[k]) || bus.out_sat !== 1'b0) begin
                    fails++; $display("FAIL round_data k=%0d: got %0d sat %b want %0d sat 0", k, bus.out_data, bus.out_sat, y[k]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        int         ed [16];
        logic [15:0] es;
        int         k;
        logic       ev;
        ed = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
               32767, 32767, 32767, -4, -32768, -32768, -32768, -32768};
        es = 16'b1111_0111_1111_1110;
        do_reset();
        cset = '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 16384};
        load_shadow();
        swap_bank();
        for (int c = 0; c < 16 + LAT + 1; c++) begin
            drive(c < 16, (c < 8) ? 32767 : -32768);
            k  = c - LAT;
            ev = (k >= 0) && (k < 16);
            tests++;
            if (bus.out_valid !== ev) begin fails++; $display("FAIL sat_valid c=%0d: got %b want %b", c, bus.out_valid, ev); end
            if (ev) begin
                tests++;
                if (bus.out_data !== DATA_W'(ed[k]) || bus.out_sat !== es[k]) begin
                    fails++; $display("FAIL sat_data k=%0d: got %0d sat %b want %0d sat %b", k, bus.out_data, bus.out_sat, ed[k], es[k]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_swap_midstream();
        int   k;
        int   exp_d;
        logic ev;
        do_reset();
        cset = '{1, 1, 1, 1, 1, 1, 1, 1};
        load_shadow();
        swap_bank();
        cset = '{2, 2, 2, 2, 2, 2, 2, 2};
        load_shadow();
        for (int c = 0; c < 20 + LAT + 2; c++) begin
            bus.coef_swap  = (c == 12) || (c == 16);
            bus.coef_we    = (c == 12);
            bus.coef_addr  = 8'd0;
            bus.coef_wdata = COEF_W'(100);
            drive(c < 20, 16384);
            k  = c - LAT;
            ev = (k >= 0) && (k < 20);
            tests++;
            if (bus.out_valid !== ev) begin fails++; $display("FAIL swap_valid c=%0d: got %b want %b", c, bus.out_valid, ev); end
            if (ev) begin
                if (k < 8)       exp_d = k + 1;
                else if (k < 12) exp_d = 8;
                else if (k < 16) exp_d = 16;
                else             exp_d = 114;
                tests++;
                if (bus.out_data !== DATA_W'(exp_d)) begin fails++; $display("FAIL swap_data k=%0d: got %0d want %0d", k, bus.out_data, exp_d); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        logic v;
        int   d;
        logic ev;
        do_reset();
        cset = '{1, 1, 1, 1, 1, 1, 1, 1};
        load_shadow();
        swap_bank();
        for (int c = 0; c < 14; c++) begin
            idle_inputs();
            rst = 1'b0;
            v   = 1'b0;
            d   = 0;
            if (c < 3 || c == 4 || c == 6) begin
                v = 1'b1;
                d = 16384;
            end
            if (c == 3) begin
                rst            = 1'b1;
                v              = 1'b1;
                d              = 16384;
                bus.coef_we    = 1'b1;
                bus.coef_addr  = 8'd0;
                bus.coef_wdata = COEF_W'(777);
                bus.coef_swap  = 1'b1;
            end
            if (c == 5) bus.coef_swap = 1'b1;
            drive(v, d);
            ev = (c == 9) || (c == 11);
            tests++;
            if (bus.out_valid !== ev) begin fails++; $display("FAIL rstmid_valid c=%0d: got %b want %b", c, bus.out_valid, ev); end
            tests++;
            if (bus.out_data !== 16'sd0 || bus.out_sat !== 1'b0) begin
                fails++; $display("FAIL rstmid_data c=%0d: got %0d sat %b want 0 sat 0", c, bus.out_data, bus.out_sat);
            end
        end
        idle_inputs();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_impulse();
        test_bubbles();
        test_rounding();
        test_saturation();
        test_swap_midstream();
        test_reset_midstream();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_pipe_cfg.md
FIR_PIPE_CFG -- requirements
Module: fir_pipe_cfg

Interface
REQ-001 SHALL have parameter DATA_W, default 16: signed sample width for input and output.
REQ-002 SHALL have parameter COEF_W, default 16: signed coefficient width.
REQ-003 SHALL have parameter NTAPS, default 123: tap count, legal range 2..256.
REQ-004 SHALL have parameter FRAC, default 14: coefficient fractional bits (Q-format).
REQ-005 SHALL have derived constant T = clog2(NTAPS), the adder-tree depth, and ACC_W = DATA_W+COEF_W+T, the accumulator width.
REQ-006 SHALL have port clk, input, 1 bit: clock; all logic rising-edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data valid this cycle.
REQ-009 SHALL have port in_data, input, DATA_W bits: signed sample.
REQ-010 SHALL have port coef_we, input, 1 bit: shadow coefficient write strobe.
REQ-011 SHALL have port coef_addr, input, 8 bits: tap index to write.
REQ-012 SHALL have port coef_wdata, input, COEF_W bits: signed coefficient.
REQ-013 SHALL have port coef_swap, input, 1 bit: copy the shadow bank to the active bank.
REQ-014 SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-015 SHALL have port out_data, output, DATA_W bits: filtered, rounded, saturated sample.
REQ-016 SHALL have port out_sat, output, 1 bit: out_data was clipped; qualified by out_valid.

Function
REQ-017 SHALL shift the sample delay line by one tap only on edges where in_valid=1, with tap0 taking in_data; with in_valid=0 the line holds.
REQ-018 SHALL register all NTAPS full-width products (DATA_W+COEF_W bits, no truncation) one edge after acceptance.
REQ-019 SHALL sum the products in a registered binary adder tree of T levels at ACC_W bits, with no intermediate truncation.
REQ-020 SHALL round the sum half-up by adding 2^(FRAC-1), then arithmetic-shift it right by FRAC.
REQ-021 SHALL saturate the rounded result to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set out_sat=1 whenever clipping occurs.
REQ-022 SHALL register out_data, out_valid and out_sat in a final stage.
REQ-023 SHALL assert out_valid exactly LAT = T+2 cycles after each accepting edge, with one output per accepted sample.
REQ-024 SHALL carry the valid flag through the pipeline with the data, so that the out_valid pattern is the in_valid pattern delayed by LAT.
REQ-025 SHALL hold out_data and out_sat at their last values while out_valid=0.
REQ-026 SHALL have no backpressure: the pipeline advances every cycle.
REQ-027 SHALL write coef_wdata to shadow[coef_addr] on coef_we=1, and ignore the write when coef_addr >= NTAPS.
REQ-028 SHALL load the active bank from the shadow bank on coef_swap=1 within one edge.
REQ-029 SHALL use the new coefficients for products registered on the edge after a swap; products already registered keep the old coefficients.
REQ-030 SHALL, when coef_we and coef_swap occur in the same cycle, copy the pre-write shadow contents; the write lands in shadow only.
REQ-031 SHALL never stall or drop samples during coefficient writes or swaps.

Reset
REQ-032 SHALL, on rst=1 at an edge, clear the delay line, product registers, tree registers and valid pipeline.
REQ-033 SHALL, on rst=1 at an edge, drive out_valid=0, out_data=0 and out_sat=0.
REQ-034 SHALL, on rst=1 at an edge, clear both coefficient banks to 0.
REQ-035 SHALL, when rst=1 mid-stream, discard all in-flight samples, so that no out_valid occurs for samples accepted before the reset.
REQ-036 SHALL give rst priority over in_valid, coef_we and coef_swap in the same cycle.

Structure
REQ-037 SHALL place the default parameter values, the clog2 function and a saturate/round helper in shared package fir_pkg.
REQ-038 SHALL implement the registered adder tree as sub-module fir_adder_tree, parameterised by N and width, with latency T.

Verification
REQ-039 SHALL cover impulse response: NTAPS=8, coefficients 1..8 loaded and swapped, input 16384 followed by 7 zeros -> out_data 1,2,...,8, first output LAT=5 cycles after the impulse.
REQ-040 SHALL cover saturation: NTAPS=8, all coefficients 16384, continuous input 32767 -> eighth output 32767 with out_sat=1; input -32768 -> out_data -32768 with out_sat=1.
REQ-041 SHALL cover rounding: single coefficient 1, others 0 -> input 8192 gives 1, input 8191 gives 0, input -8192 gives 0, input -8193 gives -1.
REQ-042 SHALL cover bubbles: in_valid pattern 1,0,0,1,1,0,1 -> out_valid shows the same pattern delayed by LAT, with out_data identical to the dense-stream run.
REQ-043 SHALL cover swap mid-stream: constant input 16384, shadow bank set to 2x the active bank, swap -> outputs switch cleanly from the old to the new response at the defined boundary, with no mixed-coefficient products.
REQ-044 SHALL cover reset mid-stream: rst pulsed with 3 samples in flight -> no out_valid for those samples, out_data=0, and the first post-reset sample is filtered with zero coefficients until reload.
